pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards, multi-cycle data-memory waits, and taken-branch flushes.
- Keeps saturating event counters for performance debug, plus a sticky memory-timeout error.

---
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, data-memory wait and branch flush.
// Control outputs are combinational from state and inputs; state and counters are registered.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic hold;
  logic freeze;
  logic lu;
  logic win_freeze;
  logic win_lu;
  logic win_flush;

  always_comb begin
    hold   = (state == IDLE) || !start_i;
    freeze = ((state == RUN) && mem_req_i && !mem_ack_i) ||
             ((state == MEM_WAIT) && !mem_ack_i);
    lu     = ex_memread_i && (ex_rd_addr_i != 5'd0) &&
             ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
    win_freeze = !hold && freeze;
    win_lu     = !hold && !freeze && lu;
    win_flush  = !hold && !freeze && !lu && branch_taken_i;
  end

  always_comb begin
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (hold) begin
      // everything frozen, nothing bubbled
    end else if (freeze) begin
      mem_wb_bubble_o = 1'b1;
    end else if (lu) begin
      id_ex_write_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      ex_mem_write_o = 1'b1;
    end else begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = branch_taken_i;
      id_ex_write_o  = 1'b1;
      ex_mem_write_o = 1'b1;
    end
  end

  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) state <= RUN;
        end
        RUN: begin
          if (start_i && mem_req_i && !mem_ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state <= RUN;
          end else begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST) err_timeout_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Event counters saturate so long runs never alias back to small values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      freeze_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (win_lu && stall_cnt_o != CNT_MAX)      stall_cnt_o  <= stall_cnt_o + 1'b1;
      if (win_freeze && freeze_cnt_o != CNT_MAX) freeze_cnt_o <= freeze_cnt_o + 1'b1;
      if (win_flush && flush_cnt_o != CNT_MAX)   flush_cnt_o  <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a priority-rule model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, start_i, ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;

  logic       a_pc, a_ifw, a_ifl, a_idw, a_idb, a_exw, a_mwb, a_err, b_pc, b_ifw, b_ifl, b_idw, b_idb, b_exw, b_mwb, b_err;
  logic [1:0] a_state, b_state;
  logic [7:0] a_stall, a_freeze, a_flush;
  logic [1:0] b_stall, b_freeze, b_flush;

  pipeline_hazard_ctrl #(.CNT_W(8), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .ex_memread_i(ex_memread_i), .ex_rd_addr_i(ex_rd_addr_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(a_pc), .if_id_write_o(a_ifw), .if_id_flush_o(a_ifl),
    .id_ex_write_o(a_idw), .id_ex_bubble_o(a_idb), .ex_mem_write_o(a_exw),
    .mem_wb_bubble_o(a_mwb), .state_o(a_state), .stall_cnt_o(a_stall),
    .freeze_cnt_o(a_freeze), .flush_cnt_o(a_flush), .err_timeout_o(a_err)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .TIMEOUT(TO)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .ex_memread_i(ex_memread_i), .ex_rd_addr_i(ex_rd_addr_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(b_pc), .if_id_write_o(b_ifw), .if_id_flush_o(b_ifl),
    .id_ex_write_o(b_idw), .id_ex_bubble_o(b_idb), .ex_mem_write_o(b_exw),
    .mem_wb_bubble_o(b_mwb), .state_o(b_state), .stall_cnt_o(b_stall),
    .freeze_cnt_o(b_freeze), .flush_cnt_o(b_flush), .err_timeout_o(b_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state 0/1/2, consecutive unacked wait cycles, sticky error, counters
  int m_state, m_nwait, m_err;
  int ca_stall, ca_freeze, ca_flush, cb_stall, cb_freeze, cb_flush;

  function automatic int sat(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  task automatic model_reset();
    m_state = 0; m_nwait = 0; m_err = 0;
    ca_stall = 0; ca_freeze = 0; ca_flush = 0;
    cb_stall = 0; cb_freeze = 0; cb_flush = 0;
  endtask

  task automatic step(input logic r, input logic s, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic mr, input logic [4:0] rd, input logic br, input logic rq, input logic ak);
    int  win;
    logic hold, frz, lu;
    rst_i = r; start_i = s; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    ex_memread_i = mr; ex_rd_addr_i = rd; branch_taken_i = br; mem_req_i = rq; mem_ack_i = ak;
    hold = (m_state == 0) || !s;
    frz  = (m_state == 1 && rq && !ak) || (m_state == 2 && !ak);
    lu   = mr && rd != 0 && (rd == rs1 || rd == rs2);
    // 0 hold, 1 freeze, 2 load-use, 3 flush, 4 normal
    win  = hold ? 0 : frz ? 1 : lu ? 2 : br ? 3 : 4;
    @(negedge clk_i);
    check("pc_write",   32'(a_pc),  32'(win >= 3));
    check("if_id_write", 32'(a_ifw), 32'(win >= 3));
    check("if_id_flush", 32'(a_ifl), 32'(win == 3));
    check("id_ex_write", 32'(a_idw), 32'(win >= 2));
    check("id_ex_bubble", 32'(a_idb), 32'(win == 2));
    check("ex_mem_write", 32'(a_exw), 32'(win >= 2));
    check("mem_wb_bubble", 32'(a_mwb), 32'(win == 1));
    check("state", 32'(a_state), 32'(m_state));
    check("err", 32'(a_err), 32'(m_err));
    check("stall_cnt", 32'(a_stall), 32'(ca_stall));
    check("freeze_cnt", 32'(a_freeze), 32'(ca_freeze));
    check("flush_cnt", 32'(a_flush), 32'(ca_flush));
    check("sat_stall_cnt", 32'(b_stall), 32'(cb_stall));
    check("sat_freeze_cnt", 32'(b_freeze), 32'(cb_freeze));
    check("sat_flush_cnt", 32'(b_flush), 32'(cb_flush));
    @(posedge clk_i);
    if (r) begin
      model_reset();
    end else begin
      if (win == 2) begin ca_stall = sat(ca_stall, 255);   cb_stall = sat(cb_stall, 3);   end
      if (win == 1) begin ca_freeze = sat(ca_freeze, 255); cb_freeze = sat(cb_freeze, 3); end
      if (win == 3) begin ca_flush = sat(ca_flush, 255);   cb_flush = sat(cb_flush, 3);   end
      if (m_state == 0) begin
        if (s) m_state = 1;
      end else if (m_state == 1) begin
        if (s && rq && !ak) begin m_state = 2; m_nwait = 0; end
      end else begin
        if (ak) m_state = 1;
        else begin
          m_nwait++;
          if (m_nwait >= TO) m_err = 1;
        end
      end
    end
    #1;
  endtask

  task automatic nop();
    step(0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1; start_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; ex_memread_i = 0;
    ex_rd_addr_i = 0; branch_taken_i = 0; mem_req_i = 0; mem_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    // idle hold, then start
    repeat (3) step(0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
    nop(); nop();
    // load-use on rs2, then rd=x0 must not stall
    step(0, 1, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0);
    nop();
    step(0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    check("lu_stall_once", 32'(a_stall), 32'd1);
    // four-cycle memory wait then ack
    repeat (4) step(0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
    step(0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
    nop();
    check("freeze_four", 32'(a_freeze), 32'd4);
    // branch suppressed by load-use, re-resolves next cycle
    step(0, 1, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0);
    step(0, 1, 5'd7, 5'd2, 0, 5'd7, 1, 0, 0);
    nop();
    check("flush_once", 32'(a_flush), 32'd1);
    // timeout: ack withheld six cycles, error survives ack
    repeat (6) step(0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
    step(0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
    nop();
    check("err_sticky", 32'(a_err), 32'd1);
    // reset in the middle of a wait with ack pending
    repeat (2) step(0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
    step(1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
    step(0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
    check("rst_err_clear", 32'(a_err), 32'd0);
    check("rst_state_idle", 32'(a_state), 32'd0);
    nop();
    // six load-use stalls saturate a 2-bit counter
    repeat (6) begin
      step(0, 1, 5'd9, 5'd4, 1, 5'd9, 0, 0, 0);
      nop();
    end
    check("stall_saturated", 32'(b_stall), 32'd3);
    check("stall_wide", 32'(a_stall), 32'd6);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 16) != 0,
           5'($urandom % 4), 5'($urandom % 4), 1'($urandom % 2), 5'($urandom % 4),
           ($urandom % 4) == 0, ($urandom % 3) == 0, 1'($urandom % 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
